lab71soc_mem_tester: RTL and testbench
======================================

# lab71soc_mem_tester

Avalon-MM master that drives the 4×32 on-chip RAM slave directly, with no interconnect between them. On `start` it fills every word with a selected test pattern, reads each word back through the RAM's one-cycle read path, and compares it against the expected value. It reports pass/fail, a mismatch count and the first failing address. It gives a hardware self-test of the on-chip memory without involving the Nios II.

## Interface
Parameters:
- `DEPTH`, 4: number of 32-bit words tested (addresses 0..DEPTH-1).
- `ADDR_W`, 2: address width, equal to clog2(DEPTH).
- `SEED`, 32'hA5A5_0000: base value for patterns 2 and 3.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `pattern_sel` in 2: pattern mode, latched when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until DONE ends.
- `done` out 1: one-cycle pulse when results are valid.
- `pass` out 1: `err_count`==0, updated in DONE and held until the next accept.
- `err_count` out clog2(DEPTH+1): number of mismatches, saturating at DEPTH.
- `first_err_addr` out ADDR_W: address of the first mismatch; 0 if there was none.
- `avm_address` out ADDR_W, `avm_byteenable` out 4, `avm_chipselect` out 1, `avm_write` out 1, `avm_writedata` out 32: registered master outputs.
- `avm_clken` out 1: constant 1 out of reset.
- `avm_readdata` in 32: slave read data, valid in the cycle after the address is presented.

## Operation
- Expected data for address a, as p(a):
  - Mode 0: {30'b0, a}.
  - Mode 1: 32'h1 << (8·a).
  - Mode 2: SEED ^ {4{6'b0, a}}.
  - Mode 3: the bitwise inverse of mode 2.
- FSM states are IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- **IDLE:** All avm strobes are 0. When `start`=1, clear `err_count` and `first_err_addr`, latch `pattern_sel`, and go to WRITE.
- **WRITE:** Lasts DEPTH cycles. In each cycle drive `avm_chipselect`=1, `avm_write`=1, `avm_byteenable`=4'hF, `avm_address`=a and `avm_writedata`=p(a), for a=0..DEPTH-1. After the last address go to READ.
- **READ:** Lasts DEPTH cycles. Drive `avm_chipselect`=1, `avm_write`=0 and `avm_address`=a. Register a delayed copy, addr_d, of the address.
  - From the second READ cycle onward, compare `avm_readdata` against p(addr_d).
- **DRAIN:** One cycle. Compare the last word. Strobes are 0.
- **Mismatch handling:** On any mismatch, increment `err_count`, saturating at DEPTH. If it is the first mismatch of the run, capture addr_d into `first_err_addr`.
- **DONE:** One cycle. `done`=1, `pass`=(`err_count`==0), `busy` stays 1. Next state is IDLE.
- `start` asserted in any state other than IDLE is ignored and is not queued.
- **Reset:** Assertion in any state, including mid-WRITE, returns the FSM to IDLE immediately.
  - Output values during reset: `busy`/`done`/`pass`=0, `err_count`/`first_err_addr`=0, all avm outputs 0 except `avm_clken`=1.
  - Memory contents left by a partial run are undefined. The tester makes no attempt to restore them.

## Timing
- Count `start` sampled at edge E0 as cycle 0.
- WRITE occupies cycles 1..DEPTH, READ occupies DEPTH+1..2·DEPTH, and DRAIN is 2·DEPTH+1.
- DONE and the `done` pulse fall in cycle 2·DEPTH+2, which is cycle 10 for DEPTH=4.
- `busy` is high in cycles 1..2·DEPTH+2.
- A new `start` is accepted at the earliest in cycle 2·DEPTH+3.
- Read latency is fixed at 1. No waitrequest is present and none is handled.
- `err_count` never wraps. `first_err_addr` is written at most once per run.

## Structure
- Package `lab71soc_memtest_pkg` holds:
  - the state enum;
  - pattern mode constants PAT_ADDR, PAT_WALK, PAT_SEED, PAT_INV;
  - the pure function `pattern(mode, addr, seed)`.
- The top level contains the FSM, the address counter, addr_d and the result registers.
- One sub-module is natural: `lab71soc_memtest_cmp`. It is combinational: it takes readdata, the expected value and the enable, and produces the mismatch flag.

## Test plan
- Memory model + `start`, `pattern_sel`=0, DEPTH=4:
  - Writes 0,1,2,3 to addresses 0..3 in cycles 1..4.
  - Reads in cycles 5..8.
  - `done` in cycle 10 with `pass`=1, `err_count`=0, `first_err_addr`=0.
- `pattern_sel`=1: writedata sequence is 0x00000001, 0x00000100, 0x00010000, 0x01000000. Result `pass`=1.
- `pattern_sel`=2, then a separate run with `pattern_sel`=3:
  - `pattern_sel`=2 writes 0xA6A60303 at address 3.
  - `pattern_sel`=3 writes 0x5959FCFC at address 3.
  - Both runs report `pass`=1.
- Fault injection on the model, `pattern_sel`=0:
  - readdata bit 0 stuck-at-0 at address 3: `err_count`=1, `first_err_addr`=3, `pass`=0.
  - All reads forced to 0xFFFFFFFF: `err_count`=4, `first_err_addr`=0.
- `start` re-pulsed in cycles 3 and 9: ignored, with exactly one `done` in cycle 10. A subsequent `start` in cycle 11 gives `done` in cycle 21.
- `reset` asserted in cycle 3 of a run: all outputs take their reset values immediately and `busy`=0. A following `start` completes normally in 10 cycles with `pass`=1.

Source files
------------

// File: rtl/lab71soc_memtest_pkg.sv
// Shared types for the on-chip RAM self-test: FSM states, pattern modes and
// the expected-data generator used on both the write and the compare side.
package lab71soc_memtest_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_WALK = 2'd1;
  localparam logic [1:0] PAT_SEED = 2'd2;
  localparam logic [1:0] PAT_INV  = 2'd3;

  // Address is widened to a byte so the seed pattern can replicate it per lane.
  function automatic logic [31:0] pattern(input logic [1:0]  mode,
                                          input logic [7:0]  addr,
                                          input logic [31:0] seed);
    logic [31:0] seeded;
    seeded = seed ^ {4{addr}};
    case (mode)
      PAT_ADDR: return {24'b0, addr};
      PAT_WALK: return 32'h1 << {addr, 3'b000};
      PAT_SEED: return seeded;
      default:  return ~seeded;
    endcase
  endfunction

endpackage

// File: rtl/lab71soc_memtest_cmp.sv
// Read-back comparator: flags a mismatch between returned and expected data.
// Purely combinational; no state, no backpressure.
module lab71soc_memtest_cmp (
  input  logic [31:0] rdata_i,
  input  logic [31:0] expected_i,
  input  logic        en_i,
  output logic        mismatch_o
);

  assign mismatch_o = en_i && (rdata_i != expected_i);

endmodule

// File: rtl/lab71soc_mem_tester.sv
// Avalon-MM memory self-test master: write pattern, read back, count mismatches.
// Fixed 2*DEPTH+2 cycles from accepted start to done; no waitrequest, busy start ignored.
module lab71soc_mem_tester
  import lab71soc_memtest_pkg::*;
#(
  parameter int          DEPTH  = 4,
  parameter int          ADDR_W = 2,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   pattern_sel,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(DEPTH+1)-1:0]   err_count,
  output logic [ADDR_W-1:0]            first_err_addr,
  output logic [ADDR_W-1:0]            avm_address,
  output logic [3:0]                   avm_byteenable,
  output logic                         avm_chipselect,
  output logic                         avm_write,
  output logic [31:0]                  avm_writedata,
  output logic                         avm_clken,
  input  logic [31:0]                  avm_readdata
);

  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  SAT   = CNT_W'(DEPTH);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_dly_q;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic               pass_q, pass_d;

  logic [ADDR_W-1:0]  av_addr_q, av_addr_d;
  logic [3:0]         av_be_q, av_be_d;
  logic               av_cs_q, av_cs_d;
  logic               av_wr_q, av_wr_d;
  logic [31:0]        av_wdata_q, av_wdata_d;

  logic               cmp_en;
  logic               mismatch;
  logic [31:0]        expected;

  // Read data lags the address by one cycle, so compare against the delayed address.
  assign cmp_en   = ((state_q == S_READ) && (cnt_q != '0)) || (state_q == S_DRAIN);
  assign expected = pattern(mode_q, 8'(addr_dly_q), SEED);

  lab71soc_memtest_cmp u_cmp (
    .rdata_i    (avm_readdata),
    .expected_i (expected),
    .en_i       (cmp_en),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          cnt_d   = '0;
          mode_d  = pattern_sel;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      if (err_q != SAT) begin
        err_d = err_q + CNT_W'(1);
      end
      if (err_q == '0) begin
        first_d = addr_dly_q;
      end
    end

    if (state_d == S_DONE) begin
      pass_d = (err_d == '0);
    end
  end

  // Bus strobes are computed from the next state so they are registered outputs.
  always_comb begin
    av_addr_d  = '0;
    av_be_d    = 4'h0;
    av_cs_d    = 1'b0;
    av_wr_d    = 1'b0;
    av_wdata_d = '0;
    if (state_d == S_WRITE) begin
      av_addr_d  = cnt_d;
      av_be_d    = 4'hF;
      av_cs_d    = 1'b1;
      av_wr_d    = 1'b1;
      av_wdata_d = pattern(mode_d, 8'(cnt_d), SEED);
    end else if (state_d == S_READ) begin
      av_addr_d = cnt_d;
      av_be_d   = 4'hF;
      av_cs_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_dly_q <= '0;
      mode_q     <= PAT_ADDR;
      err_q      <= '0;
      first_q    <= '0;
      pass_q     <= 1'b0;
      av_addr_q  <= '0;
      av_be_q    <= 4'h0;
      av_cs_q    <= 1'b0;
      av_wr_q    <= 1'b0;
      av_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_dly_q <= cnt_q;
      mode_q     <= mode_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pass_q     <= pass_d;
      av_addr_q  <= av_addr_d;
      av_be_q    <= av_be_d;
      av_cs_q    <= av_cs_d;
      av_wr_q    <= av_wr_d;
      av_wdata_q <= av_wdata_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign avm_address    = av_addr_q;
  assign avm_byteenable = av_be_q;
  assign avm_chipselect = av_cs_q;
  assign avm_write      = av_wr_q;
  assign avm_writedata  = av_wdata_q;
  assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_lab71soc_mem_tester.sv
// Directed bench: RAM model with fault injection, write/result scoreboards.
module tb_lab71soc_mem_tester;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  pattern_sel;
  logic        busy, done, pass;
  logic [2:0]  err_count;
  logic [1:0]  first_err_addr;
  logic [1:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [31:0] avm_writedata, avm_readdata;

  int npass = 0;
  int nchk  = 0;
  int fault = 0;

  always #5 clk = ~clk;

  lab71soc_mem_tester dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata)
  );

  // Expected write data per mode/address, SEED = 0xA5A50000.
  logic [31:0] wtab [4][4] = '{
    '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003},
    '{32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000},
    '{32'hA5A5_0000, 32'hA4A4_0101, 32'hA7A7_0202, 32'hA6A6_0303},
    '{32'h5A5A_FFFF, 32'h5B5B_FEFE, 32'h5858_FDFD, 32'h5959_FCFC}
  };

  // RAM model with one-cycle read latency.
  logic [31:0] mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] rd_q = '0;
  logic [1:0]  rd_a = '0;

  always @(posedge clk) begin
    if (avm_chipselect && avm_write) begin
      for (int b = 0; b < 4; b++)
        if (avm_byteenable[b]) mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
    end
    if (avm_chipselect && !avm_write) begin
      rd_q <= mem[avm_address];
      rd_a <= avm_address;
    end
  end

  assign avm_readdata = (fault == 2) ? 32'hFFFF_FFFF :
                        (fault == 1 && rd_a == 2'd3) ? {rd_q[31:1], 1'b0} : rd_q;

  typedef struct packed {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [2:0] err;
    logic [1:0] first;
    logic       pass;
  } res_t;

  wr_t  wq[$];
  res_t rq[$];
  wr_t  wexp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && avm_chipselect && avm_write) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", 64'({avm_address, avm_writedata}), 64'h1_0000_0000_0000);
      end else begin
        wexp = wq.pop_front();
        check("wr_data", 64'({avm_address, avm_writedata}), 64'({wexp.a, wexp.d}));
      end
    end
  end

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, pass, err_count, first_err_addr, avm_address,
                avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken});
  endfunction

  task automatic run(input int mode, input int flt, input logic [2:0] e_err,
                     input logic [1:0] e_first, input logic e_pass,
                     input bit repulse, input bit do_reset);
    int   cyc;
    bit   seen;
    wr_t  w;
    res_t r;
    fault = flt;
    for (int a = 0; a < 4; a++) begin
      w.a = 2'(a);
      w.d = wtab[mode][a];
      wq.push_back(w);
    end
    r.err = e_err; r.first = e_first; r.pass = e_pass;
    rq.push_back(r);

    @(negedge clk);
    check("idle_before_start", 64'({busy, done}), 64'd0);
    pattern_sel = 2'(mode);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pattern_sel = 2'(3 - mode);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 30) begin
      @(negedge clk);
      if (do_reset && cyc == 3) begin
        #1 reset = 1'b1;
        #1 check("reset_mid_run", out_vec(), 64'd1);
        wq.delete();
        rq.delete();
        @(posedge clk);
        #1 check("reset_held", out_vec(), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      start = repulse && (cyc == 3 || cyc == 9);
      if (cyc <= 4)
        check("write_strobes", 64'({avm_chipselect, avm_write, avm_byteenable, avm_address}),
              64'({1'b1, 1'b1, 4'hF, 2'(cyc - 1)}));
      else if (cyc <= 8)
        check("read_strobes", 64'({avm_chipselect, avm_write, avm_address}),
              64'({1'b1, 1'b0, 2'(cyc - 5)}));
      else
        check("idle_strobes", 64'({avm_chipselect, avm_write}), 64'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("done_cycle", 64'(cyc), 64'd10);
    if (seen && rq.size() != 0) begin
      r = rq.pop_front();
      check("result", 64'({busy, err_count, first_err_addr, pass}),
            64'({1'b1, r.err, r.first, r.pass}));
      check("all_writes_seen", 64'(wq.size()), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pattern_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", out_vec(), 64'd1);
    reset = 1'b0;

    run(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    run(1, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    run(2, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    run(3, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    run(0, 1, 3'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    run(0, 2, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0);
    run(0, 0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    run(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    run(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    run(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    check("final_idle", 64'({busy, done, pass}), 64'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
